// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared types and defaults for the canonical-Huffman decoder
// Contents: FSM state enum, default geometry constants, error symbol value.
package huff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_MAX_LEN    = 16;
    localparam int DEF_SYM_W      = 8;
    localparam int DEF_NUM_SYM    = 256;
    localparam int DEF_NUM_TABLES = 4;

    localparam logic [DEF_SYM_W-1:0] ERR_SYMBOL = '1;

endpackage

// File: rtl/huff_table_mux.sv
// rtl/huff_table_mux.sv - combinational count/symbol selection from flattened tables
// Ports:
//   hufftable  in  : per-table code counts, byte t*MAX_LEN + (l-1)
//   huffsymbol in  : per-table symbols, entry t*NUM_SYM + i
//   tsel       in  : table pair select
//   len        in  : code length 1..MAX_LEN (0 selects nothing)
//   idx        in  : symbol index
//   cnt        out : count of codes of length len in table tsel (0 when out of range)
//   sym        out : symbol idx of table tsel (0 when out of range)
module huff_table_mux #(
    parameter int MAX_LEN    = 16,
    parameter int SYM_W      = 8,
    parameter int NUM_SYM    = 256,
    parameter int NUM_TABLES = 4,
    parameter int TSEL_W     = 2,
    parameter int LEN_W      = 5,
    parameter int IDX_W      = 10
) (
    input  logic [NUM_TABLES*MAX_LEN*8-1:0]     hufftable,
    input  logic [NUM_TABLES*NUM_SYM*SYM_W-1:0] huffsymbol,
    input  logic [TSEL_W-1:0]                   tsel,
    input  logic [LEN_W-1:0]                    len,
    input  logic [IDX_W-1:0]                    idx,
    output logic [7:0]                          cnt,
    output logic [SYM_W-1:0]                    sym
);

    always_comb begin
        cnt = '0;
        sym = '0;
        if (int'(tsel) < NUM_TABLES && len != '0 && int'(len) <= MAX_LEN) begin
            cnt = hufftable[(int'(tsel) * MAX_LEN + int'(len) - 1) * 8 +: 8];
        end
        if (int'(tsel) < NUM_TABLES && int'(idx) < NUM_SYM) begin
            sym = huffsymbol[(int'(tsel) * NUM_SYM + int'(idx)) * SYM_W +: SYM_W];
        end
    end

endmodule

// File: rtl/huff_canon_decoder.sv
// rtl/huff_canon_decoder.sv - one-length-per-cycle canonical-Huffman symbol decoder
// Ports:
//   clk, rst   in  : clock, asynchronous active-high reset
//   start      in  : request pulse, accepted in IDLE only
//   tbl_sel    in  : table pair, captured with start
//   code       in  : left-aligned bit window (MSB = next bit), captured with start
//   hufftable  in  : code counts per table and length
//   huffsymbol in  : symbol tables
//   busy       out : request in flight, up to and including done
//   done       out : one-cycle result strobe
//   symbol     out : decoded symbol, all ones on error
//   length     out : consumed bits, 0 on error
//   err        out : no code within MAX_LEN bits or symbol index out of range
module huff_canon_decoder
    import huff_pkg::*;
#(
    parameter  int MAX_LEN    = DEF_MAX_LEN,
    parameter  int SYM_W      = DEF_SYM_W,
    parameter  int NUM_SYM    = DEF_NUM_SYM,
    parameter  int NUM_TABLES = DEF_NUM_TABLES,
    localparam int TSEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [TSEL_W-1:0]                   tbl_sel,
    input  logic [MAX_LEN-1:0]                  code,
    input  logic [NUM_TABLES*MAX_LEN*8-1:0]     hufftable,
    input  logic [NUM_TABLES*NUM_SYM*SYM_W-1:0] huffsymbol,
    output logic                                busy,
    output logic                                done,
    output logic [SYM_W-1:0]                    symbol,
    output logic [LEN_W-1:0]                    length,
    output logic                                err
);

    localparam int FW     = MAX_LEN + 1;
    localparam int BASE_W = $clog2(NUM_SYM) + 2;
    localparam int IW     = FW + BASE_W;
    localparam int BSW    = BASE_W + 9;
    localparam logic [SYM_W-1:0] ERR_SYM = '1;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     l_q, l_d;
    logic [FW-1:0]        first_q, first_d;
    logic [BASE_W-1:0]    base_q, base_d;
    logic [MAX_LEN-1:0]   code_q, code_d;
    logic [TSEL_W-1:0]    tsel_q, tsel_d;
    logic [SYM_W-1:0]     symbol_q, symbol_d;
    logic [LEN_W-1:0]     length_q, length_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [7:0]           cnt;
    logic [SYM_W-1:0]     sym;
    logic [FW-1:0]        cand;
    logic [FW-1:0]        off;
    logic [IW-1:0]        idx_full;
    logic                 match;
    logic                 in_range;
    logic [FW-1:0]        first_nx;
    logic [BSW-1:0]       base_sum;
    logic [BASE_W-1:0]    base_nx;

    huff_table_mux #(
        .MAX_LEN    (MAX_LEN),
        .SYM_W      (SYM_W),
        .NUM_SYM    (NUM_SYM),
        .NUM_TABLES (NUM_TABLES),
        .TSEL_W     (TSEL_W),
        .LEN_W      (LEN_W),
        .IDX_W      (BASE_W)
    ) u_mux (
        .hufftable  (hufftable),
        .huffsymbol (huffsymbol),
        .tsel       (tsel_q),
        .len        (l_q),
        .idx        (idx_full[BASE_W-1:0]),
        .cnt        (cnt),
        .sym        (sym)
    );

    // Datapath for the length currently under test. The index is formed wide
    // so that an over-full table is reported as an error instead of wrapping.
    always_comb begin
        cand     = {1'b0, code_q} >> (MAX_LEN - int'(l_q));
        off      = cand - first_q;
        match    = (cand >= first_q) && (off < FW'(cnt));
        idx_full = IW'(base_q) + IW'(off);
        in_range = idx_full < IW'(NUM_SYM);
        first_nx = (first_q + FW'(cnt)) << 1;
        base_sum = BSW'(base_q) + BSW'(cnt);
        base_nx  = (base_sum >= BSW'(NUM_SYM)) ? BASE_W'(NUM_SYM) : base_sum[BASE_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        first_d  = first_q;
        base_d   = base_q;
        code_d   = code_q;
        tsel_d   = tsel_q;
        symbol_d = symbol_q;
        length_d = length_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d  = code;
                    tsel_d  = tbl_sel;
                    l_d     = LEN_W'(1);
                    first_d = '0;
                    base_d  = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    state_d = DONE;
                    if (in_range) begin
                        symbol_d = sym;
                        length_d = l_q;
                        err_d    = 1'b0;
                    end else begin
                        symbol_d = ERR_SYM;
                        length_d = '0;
                        err_d    = 1'b1;
                    end
                end else if (l_q == LEN_W'(MAX_LEN)) begin
                    state_d  = DONE;
                    symbol_d = ERR_SYM;
                    length_d = '0;
                    err_d    = 1'b1;
                end else begin
                    first_d = first_nx;
                    base_d  = base_nx;
                    l_d     = l_q + LEN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            l_q      <= '0;
            first_q  <= '0;
            base_q   <= '0;
            code_q   <= '0;
            tsel_q   <= '0;
            symbol_q <= ERR_SYM;
            length_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            first_q  <= first_d;
            base_q   <= base_d;
            code_q   <= code_d;
            tsel_q   <= tsel_d;
            symbol_q <= symbol_d;
            length_q <= length_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign symbol = symbol_q;
    assign length = length_q;
    assign err    = err_q;

endmodule

// File: tb/tb_huff_canon_decoder.sv
// tb/tb_huff_canon_decoder.sv - directed table-driven bench for huff_canon_decoder
module tb_huff_canon_decoder;

    localparam int MAX_LEN    = 16;
    localparam int SYM_W      = 8;
    localparam int NUM_SYM    = 256;
    localparam int NUM_TABLES = 4;

    logic                                clk = 1'b0;
    logic                                rst = 1'b1;
    logic                                start = 1'b0;
    logic [1:0]                          tbl_sel = '0;
    logic [MAX_LEN-1:0]                  code = '0;
    logic [NUM_TABLES*MAX_LEN*8-1:0]     hufftable = '0;
    logic [NUM_TABLES*NUM_SYM*SYM_W-1:0] huffsymbol = '0;
    logic                                busy;
    logic                                done;
    logic [SYM_W-1:0]                    symbol;
    logic [4:0]                          length;
    logic                                err;

    huff_canon_decoder #(
        .MAX_LEN    (MAX_LEN),
        .SYM_W      (SYM_W),
        .NUM_SYM    (NUM_SYM),
        .NUM_TABLES (NUM_TABLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tbl_sel    (tbl_sel),
        .code       (code),
        .hufftable  (hufftable),
        .huffsymbol (huffsymbol),
        .busy       (busy),
        .done       (done),
        .symbol     (symbol),
        .length     (length),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  tsel;
        logic [15:0] code;
        logic [7:0]  sym;
        logic [4:0]  len;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    int total = 0;
    int bad   = 0;

    int dc_cnt[16] = '{0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0};
    int ac_cnt[16] = '{0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125};
    logic [7:0] ac_sym[16] = '{8'h01,8'h02,8'h03,8'h00,8'h04,8'h11,8'h05,8'h12,
                               8'h21,8'h31,8'h41,8'h06,8'h13,8'h51,8'h61,8'h07};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_count(input int t, input int l, input int v);
        hufftable[(t*MAX_LEN + l - 1)*8 +: 8] = v[7:0];
    endtask

    task automatic set_sym(input int t, input int i, input logic [7:0] v);
        huffsymbol[(t*NUM_SYM + i)*SYM_W +: SYM_W] = v;
    endtask

    // Issues one request and waits (bounded) for done; lat is the number of
    // edges from the start-sampling edge to the edge that registered the result.
    task automatic run_req(input logic [1:0] t, input logic [15:0] c,
                           output logic [7:0] s, output logic [4:0] l_o,
                           output logic e, output int lat, output logic busy_ok);
        @(posedge clk); #1;
        tbl_sel = t;
        code    = c;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        code    = 16'h1234;
        tbl_sel = 2'd3;
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        s   = symbol;
        l_o = length;
        e   = err;
    endtask

    logic [7:0] r_sym;
    logic [4:0] r_len;
    logic       r_err;
    int         r_lat;
    logic       r_busy;
    int         n_done;

    initial begin
        for (int l = 1; l <= 16; l++) begin
            set_count(0, l, dc_cnt[l-1]);
            set_count(1, l, ac_cnt[l-1]);
        end
        for (int i = 0; i < 12; i++) set_sym(0, i, 8'(i));
        for (int i = 0; i < 16; i++) set_sym(1, i, ac_sym[i]);
        set_count(2, 8, 255);
        set_count(2, 9, 10);
        set_sym(2, 0, 8'h5A);
        set_sym(2, 255, 8'hAB);

        vecs[0]  = '{2'd0, 16'h0000, 8'h00, 5'd2, 1'b0, 2};
        vecs[1]  = '{2'd0, 16'h4000, 8'h01, 5'd3, 1'b0, 3};
        vecs[2]  = '{2'd0, 16'hFF00, 8'h0B, 5'd9, 1'b0, 9};
        vecs[3]  = '{2'd0, 16'hFFFF, 8'hFF, 5'd0, 1'b1, 16};
        vecs[4]  = '{2'd1, 16'hA000, 8'h00, 5'd4, 1'b0, 4};
        vecs[5]  = '{2'd1, 16'h0000, 8'h01, 5'd2, 1'b0, 2};
        vecs[6]  = '{2'd1, 16'hC000, 8'h11, 5'd4, 1'b0, 4};
        vecs[7]  = '{2'd0, 16'hA000, 8'h04, 5'd3, 1'b0, 3};
        vecs[8]  = '{2'd1, 16'hA000, 8'h00, 5'd4, 1'b0, 4};
        vecs[9]  = '{2'd2, 16'h0000, 8'h5A, 5'd8, 1'b0, 8};
        vecs[10] = '{2'd2, 16'hFF00, 8'hAB, 5'd9, 1'b0, 9};
        vecs[11] = '{2'd2, 16'hFF80, 8'hFF, 5'd0, 1'b1, 9};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_done",   32'(done),   32'h0);
        check("reset_err",    32'(err),    32'h0);
        check("reset_length", 32'(length), 32'h0);
        check("reset_symbol", 32'(symbol), 32'hFF);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            run_req(vecs[v].tsel, vecs[v].code, r_sym, r_len, r_err, r_lat, r_busy);
            check($sformatf("v%0d_symbol", v),  32'(r_sym), 32'(vecs[v].sym));
            check($sformatf("v%0d_length", v),  32'(r_len), 32'(vecs[v].len));
            check($sformatf("v%0d_err", v),     32'(r_err), 32'(vecs[v].err));
            check($sformatf("v%0d_latency", v), 32'(r_lat), 32'(vecs[v].lat));
            check($sformatf("v%0d_busy", v),    32'(r_busy), 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 32'({done, busy}), 32'h0);
        end

        // start pulsed while busy must be ignored
        @(posedge clk); #1;
        tbl_sel = 2'd0;
        code    = 16'hFF00;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        code  = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        r_sym  = 8'h00;
        r_len  = 5'd0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    r_sym = symbol;
                    r_len = length;
                end
            end
        end
        check("busy_start_done_count", 32'(n_done), 32'd1);
        check("busy_start_symbol",     32'(r_sym),  32'h0B);
        check("busy_start_length",     32'(r_len),  32'd9);

        // reset in the middle of a search
        @(posedge clk); #1;
        tbl_sel = 2'd0;
        code    = 16'hFFFF;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy",   32'(busy),   32'h0);
        check("midrst_done",   32'(done),   32'h0);
        check("midrst_err",    32'(err),    32'h0);
        check("midrst_length", 32'(length), 32'h0);
        check("midrst_symbol", 32'(symbol), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        run_req(2'd1, 16'hA000, r_sym, r_len, r_err, r_lat, r_busy);
        check("post_rst_symbol",  32'(r_sym), 32'h00);
        check("post_rst_length",  32'(r_len), 32'd4);
        check("post_rst_err",     32'(r_err), 32'h0);
        check("post_rst_latency", 32'(r_lat), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
